tdm_demux2: RTL and testbench

- Receive end of the team's 2:1 4-bit multiplexed link.
- The transmit side interleaves channel A and channel B samples on a single bus. A frame_sync flag marks each A slot.
- This block rebuilds the A/B pair, presents both channels together on registered outputs, and counts completed pairs.
- It detects slot-order violations and stalled frames, then resynchronises.

---
 rtl/tdm_demux2.sv | 133 +++++++++++++
 tb/tb_tdm_demux2.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux2.sv
// tdm_demux2: receive side of the 2:1 multiplexed sample link.
// Rebuilds A/B pairs, counts them, flags slot errors and stalls.
module tdm_demux2 #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] da_out,
  output logic [WIDTH-1:0] db_out,
  output logic             pair_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam logic [1:0] SEEK   = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] WAIT_A = 2'd2;
  localparam logic [7:0] TO     = 8'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] da_q, da_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic             pv_q, pv_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idle_q, idle_d;
  logic [7:0]       idle_inc;

  assign idle_inc = idle_q + 8'd1;

  // Slot tracking, pair assembly and error detection.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    da_d    = da_q;
    db_d    = db_q;
    pv_d    = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    case (state_q)
      SEEK: begin
        if (d_valid && frame_sync) begin
          a_d     = d_in;
          state_d = WAIT_B;
          idle_d  = '0;
        end
      end
      WAIT_B: begin
        if (d_valid) begin
          idle_d = '0;
          if (frame_sync) begin
            err_d = 1'b1;
            a_d   = d_in;
          end else begin
            da_d    = a_q;
            db_d    = d_in;
            pv_d    = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = WAIT_A;
          end
        end else if (idle_inc == TO) begin
          err_d   = 1'b1;
          state_d = SEEK;
          a_d     = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_inc;
        end
      end
      WAIT_A: begin
        if (d_valid) begin
          idle_d = '0;
          if (frame_sync) begin
            a_d     = d_in;
            state_d = WAIT_B;
          end else begin
            err_d   = 1'b1;
            state_d = SEEK;
          end
        end
      end
      default: begin
        err_d   = 1'b1;
        state_d = SEEK;
        a_d     = '0;
        idle_d  = '0;
      end
    endcase
    lock_d = (state_d != SEEK);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEEK;
      a_q     <= '0;
      da_q    <= '0;
      db_q    <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      da_q    <= da_d;
      db_q    <= db_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  assign da_out     = da_q;
  assign db_out     = db_q;
  assign pair_valid = pv_q;
  assign sync_err   = err_q;
  assign locked     = lock_q;
  assign pair_cnt   = cnt_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: directed scenarios for the 2:1 link receiver.
// Each task drives its vectors and checks against hand values.
module tb_tdm_demux2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d_in = '0;
  logic       d_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] da_out;
  logic [3:0] db_out;
  logic       pair_valid;
  logic       locked;
  logic       sync_err;
  logic [7:0] pair_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_demux2 #(
    .WIDTH(4),
    .CNT_W(8),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .d_in(d_in),
    .d_valid(d_valid),
    .frame_sync(frame_sync),
    .da_out(da_out),
    .db_out(db_out),
    .pair_valid(pair_valid),
    .locked(locked),
    .sync_err(sync_err),
    .pair_cnt(pair_cnt)
  );

  // One sample slot: drive, clock it in, settle past the edge.
  task automatic step(input logic v, input logic s,
                      input logic [3:0] d);
    d_valid = v;
    frame_sync = s;
    d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    d_valid = 1'b0;
    frame_sync = 1'b0;
    d_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (da_out !== 4'd0) begin errors++;
      $display("FAIL reset_da got=%0d exp=0", da_out); end
    checks++; if (db_out !== 4'd0) begin errors++;
      $display("FAIL reset_db got=%0d exp=0", db_out); end
    checks++; if (pair_valid !== 1'b0) begin errors++;
      $display("FAIL reset_pv got=%b exp=0", pair_valid); end
    checks++; if (locked !== 1'b0) begin errors++;
      $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (sync_err !== 1'b0) begin errors++;
      $display("FAIL reset_err got=%b exp=0", sync_err); end
    checks++; if (pair_cnt !== 8'd0) begin errors++;
      $display("FAIL reset_cnt got=%0d exp=0", pair_cnt); end
    do_reset();
  endtask

  task automatic test_basic();
    step(1'b1, 1'b1, 4'd15);
    checks++; if (locked !== 1'b1 || pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_a got lock=%b pv=%b exp 1/0",
               locked, pair_valid); end
    step(1'b1, 1'b0, 4'd10);
    checks++; if (da_out !== 4'd15 || db_out !== 4'd10) begin
      errors++;
      $display("FAIL basic_pair got=%0d/%0d exp=15/10",
               da_out, db_out); end
    checks++; if (pair_valid !== 1'b1 || pair_cnt !== 8'd1) begin
      errors++;
      $display("FAIL basic_pv got pv=%b cnt=%0d exp 1/1",
               pair_valid, pair_cnt); end
    checks++; if (locked !== 1'b1 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_lock got lock=%b err=%b exp 1/0",
               locked, sync_err); end
    step(1'b0, 1'b0, 4'd0);
    checks++; if (pair_valid !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse got pv=%b lock=%b exp 0/1",
               pair_valid, locked); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic [3:0] b;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      a = i[3:0];
      b = ~a;
      step(1'b1, 1'b1, a);
      checks++; if (pair_valid !== 1'b0 || sync_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_a%0d got pv=%b err=%b exp 0/0",
                 i, pair_valid, sync_err); end
      step(1'b1, 1'b0, b);
      checks++;
      if (da_out !== a || db_out !== b || pair_valid !== 1'b1 ||
          sync_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_b%0d got=%0d/%0d pv=%b err=%b exp=%0d/%0d 1 0",
                 i, da_out, db_out, pair_valid, sync_err, a, b); end
    end
    checks++; if (pair_cnt !== 8'd44) begin errors++;
      $display("FAIL b2b_cnt got=%0d exp=44", pair_cnt); end
  endtask

  task automatic test_repeat_a();
    step(1'b1, 1'b1, 4'd12);
    step(1'b1, 1'b1, 4'd3);
    checks++;
    if (sync_err !== 1'b1 || pair_valid !== 1'b0 || locked !== 1'b1)
    begin
      errors++;
      $display("FAIL rep_err got err=%b pv=%b lock=%b exp 1/0/1",
               sync_err, pair_valid, locked); end
    step(1'b1, 1'b0, 4'd5);
    checks++;
    if (da_out !== 4'd3 || db_out !== 4'd5 || pair_valid !== 1'b1 ||
        sync_err !== 1'b0) begin
      errors++;
      $display("FAIL rep_pair got=%0d/%0d pv=%b err=%b exp=3/5 1 0",
               da_out, db_out, pair_valid, sync_err); end
    checks++; if (pair_cnt !== 8'd45) begin errors++;
      $display("FAIL rep_cnt got=%0d exp=45", pair_cnt); end
  endtask

  task automatic test_timeout();
    step(1'b1, 1'b1, 4'd7);
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 1'b0, 4'd0);
      checks++; if (sync_err !== 1'b0 || locked !== 1'b1) begin
        errors++;
        $display("FAIL to_idle%0d got err=%b lock=%b exp 0/1",
                 k, sync_err, locked); end
    end
    step(1'b0, 1'b0, 4'd0);
    checks++; if (sync_err !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL to_fire got err=%b lock=%b exp 1/0",
               sync_err, locked); end
    checks++; if (da_out !== 4'd3 || db_out !== 4'd5) begin
      errors++;
      $display("FAIL to_hold got=%0d/%0d exp=3/5", da_out, db_out); end
    step(1'b0, 1'b0, 4'd0);
    checks++; if (sync_err !== 1'b0) begin errors++;
      $display("FAIL to_pulse got=%b exp=0", sync_err); end
    step(1'b1, 1'b1, 4'd7);
    repeat (14) step(1'b0, 1'b0, 4'd0);
    checks++; if (sync_err !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL gap14 got err=%b lock=%b exp 0/1",
               sync_err, locked); end
    step(1'b1, 1'b0, 4'd9);
    checks++;
    if (da_out !== 4'd7 || db_out !== 4'd9 || pair_valid !== 1'b1 ||
        sync_err !== 1'b0) begin
      errors++;
      $display("FAIL gap_pair got=%0d/%0d pv=%b err=%b exp=7/9 1 0",
               da_out, db_out, pair_valid, sync_err); end
  endtask

  task automatic test_b_without_a();
    step(1'b1, 1'b0, 4'd2);
    checks++; if (sync_err !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL bwa_err got err=%b lock=%b exp 1/0",
               sync_err, locked); end
    step(1'b1, 1'b0, 4'd4);
    step(1'b1, 1'b0, 4'd6);
    checks++;
    if (sync_err !== 1'b0 || pair_valid !== 1'b0 || locked !== 1'b0)
    begin
      errors++;
      $display("FAIL bwa_drop got err=%b pv=%b lock=%b exp 0/0/0",
               sync_err, pair_valid, locked); end
    step(1'b1, 1'b1, 4'd8);
    checks++; if (locked !== 1'b1) begin errors++;
      $display("FAIL bwa_relock got=%b exp=1", locked); end
    step(1'b1, 1'b0, 4'd1);
    checks++;
    if (da_out !== 4'd8 || db_out !== 4'd1 || pair_valid !== 1'b1)
    begin
      errors++;
      $display("FAIL bwa_pair got=%0d/%0d pv=%b exp=8/1 1",
               da_out, db_out, pair_valid); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (da_out !== 4'd0 || db_out !== 4'd0 || locked !== 1'b0 ||
        pair_cnt !== 8'd0 || pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst got da=%0d db=%0d lock=%b cnt=%0d pv=%b exp 0",
               da_out, db_out, locked, pair_cnt, pair_valid); end
    d_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'd2);
    checks++;
    if (pair_valid !== 1'b0 || locked !== 1'b0 || sync_err !== 1'b0)
    begin
      errors++;
      $display("FAIL arst_drop got pv=%b lock=%b err=%b exp 0/0/0",
               pair_valid, locked, sync_err); end
    step(1'b0, 1'b0, 4'd0);
    checks++; if (pair_valid !== 1'b0 || da_out !== 4'd0) begin
      errors++;
      $display("FAIL arst_after got pv=%b da=%0d exp 0/0",
               pair_valid, da_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_repeat_a();
    test_timeout();
    test_b_without_a();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
